// File: rtl/mul_share_arbiter_if.sv
// Request/response bundle between the two arithmetic clients, their consumer and
// the shared-multiplier arbiter.
interface mul_share_arbiter_if #(
    parameter int K = 16
);
    logic           req_valid_0;
    logic [K-1:0]   req_a_0;
    logic [K-1:0]   req_b_0;
    logic           req_ready_0;
    logic           req_valid_1;
    logic [K-1:0]   req_a_1;
    logic [K-1:0]   req_b_1;
    logic           req_ready_1;
    logic           rsp_valid;
    logic [2*K-1:0] rsp_data;
    logic           rsp_id;
    logic           rsp_ready;

    // Clients and the response consumer.
    modport master (
        output req_valid_0, req_a_0, req_b_0,
        output req_valid_1, req_a_1, req_b_1,
        output rsp_ready,
        input  req_ready_0, req_ready_1,
        input  rsp_valid, rsp_data, rsp_id
    );

    // The arbiter itself.
    modport slave (
        input  req_valid_0, req_a_0, req_b_0,
        input  req_valid_1, req_a_1, req_b_1,
        input  rsp_ready,
        output req_ready_0, req_ready_1,
        output rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter that lets two clients share one fixed-latency unsigned
// KxK multiplier, returning each product tagged with the issuing client id.
module mul_share_arbiter #(
    parameter int K   = 16,
    parameter int LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    mul_share_arbiter_if.slave   bus,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} stateT;

    stateT          state;
    stateT          stateNext;
    logic [3:0]     cnt;
    logic           lastGrant;
    logic           winner;
    logic           grant0;
    logic           grant1;
    logic           accept;
    logic [K-1:0]   opA;
    logic [K-1:0]   opB;
    logic           opId;
    logic           rspValid;
    logic [2*K-1:0] rspData;
    logic           rspId;

    // A tie goes to whoever did not win last time; lastGrant resets to 1 so client 0 wins first.
    always_comb begin
        winner = ~lastGrant;
        if (bus.req_valid_0 && !bus.req_valid_1) begin
            winner = 1'b0;
        end else if (bus.req_valid_1 && !bus.req_valid_0) begin
            winner = 1'b1;
        end
    end

    assign grant0 = (state == IDLE) && !rst && bus.req_valid_0 && !winner;
    assign grant1 = (state == IDLE) && !rst && bus.req_valid_1 && winner;
    assign accept = grant0 || grant1;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept)        stateNext = BUSY;
            BUSY:    if (cnt == 4'd1)   stateNext = RESP;
            RESP:    if (bus.rsp_ready) stateNext = IDLE;
            default:                    stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // The product is only produced on the last BUSY edge, so a reset mid-op silently drops it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 4'd0;
            lastGrant <= 1'b1;
            opA       <= '0;
            opB       <= '0;
            opId      <= 1'b0;
            rspValid  <= 1'b0;
            rspData   <= '0;
            rspId     <= 1'b0;
        end else begin
            if (accept) begin
                opA       <= grant1 ? bus.req_a_1 : bus.req_a_0;
                opB       <= grant1 ? bus.req_b_1 : bus.req_b_0;
                opId      <= grant1;
                lastGrant <= grant1;
                cnt       <= 4'(LAT);
            end
            if (state == BUSY) begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) begin
                    rspData  <= (2*K)'(opA) * (2*K)'(opB);
                    rspId    <= opId;
                    rspValid <= 1'b1;
                end
            end
            if (state == RESP && bus.rsp_ready) begin
                rspValid <= 1'b0;
            end
        end
    end

    assign bus.req_ready_0 = grant0;
    assign bus.req_ready_1 = grant1;
    assign bus.rsp_valid   = rspValid;
    assign bus.rsp_data    = rspData;
    assign bus.rsp_id      = rspId;
    assign busy            = (state != IDLE);
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Drives identical traffic into a LAT=2 and a LAT=1 arbiter and checks both
// against a transaction-level model of the sharing rules.
module tb_mul_share_arbiter;
    localparam int K = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         v0 = 1'b0;
    logic         v1 = 1'b0;
    logic         rr = 1'b0;
    logic [K-1:0] a0 = '0;
    logic [K-1:0] b0 = '0;
    logic [K-1:0] a1 = '0;
    logic [K-1:0] b1 = '0;
    logic         busyA;
    logic         busyB;

    mul_share_arbiter_if #(.K(K)) busA ();
    mul_share_arbiter_if #(.K(K)) busB ();

    assign busA.req_valid_0 = v0;
    assign busA.req_a_0     = a0;
    assign busA.req_b_0     = b0;
    assign busA.req_valid_1 = v1;
    assign busA.req_a_1     = a1;
    assign busA.req_b_1     = b1;
    assign busA.rsp_ready   = rr;
    assign busB.req_valid_0 = v0;
    assign busB.req_a_0     = a0;
    assign busB.req_b_0     = b0;
    assign busB.req_valid_1 = v1;
    assign busB.req_a_1     = a1;
    assign busB.req_b_1     = b1;
    assign busB.rsp_ready   = rr;

    mul_share_arbiter #(.K(K), .LAT(2)) dutA (
        .clk  (clk),
        .rst  (rst),
        .bus  (busA.slave),
        .busy (busyA)
    );

    mul_share_arbiter #(.K(K), .LAT(1)) dutB (
        .clk  (clk),
        .rst  (rst),
        .bus  (busB.slave),
        .busy (busyB)
    );

    always #5 clk = ~clk;

    // Model state: one outstanding op per DUT, tracked by edges elapsed since its accept.
    bit           inFlight[2];
    int           age[2];
    logic [31:0]  expData[2];
    logic [31:0]  lastData[2];
    bit           expId[2];
    bit           lastGrant[2];
    int           errors = 0;
    int           checks = 0;

    function automatic int latOf(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic void modelReset();
        for (int d = 0; d < 2; d++) begin
            inFlight[d]  = 1'b0;
            age[d]       = 0;
            expData[d]   = '0;
            lastData[d]  = '0;
            expId[d]     = 1'b0;
            lastGrant[d] = 1'b1;
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, compare both DUTs with the model, then advance the model past the edge.
    task automatic applyStimulus(input bit r, input bit iv0, input logic [K-1:0] ia0, input logic [K-1:0] ib0,
                                 input bit iv1, input logic [K-1:0] ia1, input logic [K-1:0] ib1, input bit irr);
        bit          w;
        bit          er0;
        bit          er1;
        bit          ev;
        logic        oR0, oR1, oV, oId, oBusy;
        logic [31:0] oData;
        @(negedge clk);
        rst = r; v0 = iv0; a0 = ia0; b0 = ib0; v1 = iv1; a1 = ia1; b1 = ib1; rr = irr;
        #1;
        for (int d = 0; d < 2; d++) begin
            oR0   = (d == 0) ? busA.req_ready_0 : busB.req_ready_0;
            oR1   = (d == 0) ? busA.req_ready_1 : busB.req_ready_1;
            oV    = (d == 0) ? busA.rsp_valid   : busB.rsp_valid;
            oData = (d == 0) ? busA.rsp_data    : busB.rsp_data;
            oId   = (d == 0) ? busA.rsp_id      : busB.rsp_id;
            oBusy = (d == 0) ? busyA            : busyB;

            if (iv0 && !iv1)      w = 1'b0;
            else if (iv1 && !iv0) w = 1'b1;
            else                  w = !lastGrant[d];
            er0 = !inFlight[d] && !r && iv0 && !w;
            er1 = !inFlight[d] && !r && iv1 && w;
            ev  = inFlight[d] && (age[d] >= latOf(d));

            checkOutput($sformatf("lat%0d.ready0", latOf(d)), 64'(oR0), 64'(er0));
            checkOutput($sformatf("lat%0d.ready1", latOf(d)), 64'(oR1), 64'(er1));
            checkOutput($sformatf("lat%0d.rspValid", latOf(d)), 64'(oV), 64'(ev));
            checkOutput($sformatf("lat%0d.busy", latOf(d)), 64'(oBusy), 64'(inFlight[d]));
            checkOutput($sformatf("lat%0d.rspData", latOf(d)), 64'(oData), 64'(ev ? expData[d] : lastData[d]));
            if (ev) checkOutput($sformatf("lat%0d.rspId", latOf(d)), 64'(oId), 64'(expId[d]));

            if (r) begin
                inFlight[d]  = 1'b0;
                age[d]       = 0;
                lastData[d]  = '0;
                lastGrant[d] = 1'b1;
            end else if (inFlight[d]) begin
                if (ev && irr) begin
                    inFlight[d] = 1'b0;
                    lastData[d] = expData[d];
                end else begin
                    age[d]++;
                end
            end else if (er0 || er1) begin
                inFlight[d]  = 1'b1;
                age[d]       = 0;
                expId[d]     = er1;
                expData[d]   = er1 ? (32'(ia1) * 32'(ib1)) : (32'(ia0) * 32'(ib0));
                lastGrant[d] = er1;
            end
        end
    endtask

    function automatic logic [K-1:0] pickOperand();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return K'($urandom);
        endcase
    endfunction

    initial begin
        modelReset();
        repeat (2) @(posedge clk);

        // Reset held, then a single request from client 0.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 16'h0003, 16'h0005, 0, 0, 0, 1);
        repeat (5) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);

        // Ties with both clients valid: grants must alternate.
        repeat (16) applyStimulus(0, 1, 16'd2, 16'd3, 1, 16'd4, 16'd5, 1);
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);

        // Back-pressure on the maximum product.
        applyStimulus(0, 1, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0);
        repeat (8) applyStimulus(0, 1, 16'h0001, 16'h0001, 1, 16'h0002, 16'h0002, 0);
        repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);

        // Lone client 1 streaming three operand pairs.
        repeat (4) applyStimulus(0, 0, 0, 0, 1, 16'h1234, 16'h0010, 1);
        repeat (4) applyStimulus(0, 0, 0, 0, 1, 16'h0000, 16'h7FFF, 1);
        repeat (4) applyStimulus(0, 0, 0, 0, 1, 16'h8000, 16'h0002, 1);
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);

        // Client 1 wins, reset hits mid-op, then a tie must go to client 0.
        applyStimulus(0, 0, 0, 0, 1, 16'd7, 16'd9, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (6) applyStimulus(0, 1, 16'd11, 16'd13, 1, 16'd17, 16'd19, 1);

        // Randomized traffic with occasional resets and back-pressure.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 9) < 6, pickOperand(), pickOperand(),
                          $urandom_range(0, 9) < 6, pickOperand(), pickOperand(),
                          $urandom_range(0, 2) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
